// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
// UART receiver driven by a 16x oversample tick. The line is synchronised, the
// start-bit edge is confirmed at mid-bit, data bits are sampled every 16 ticks
// (LSB first), and the finished word is handed off through a valid/ready output
// register. Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    // Bit counter must be able to hold DATA_BITS itself after the final increment.
    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_tick_cnt;
    logic [3:0]             w_tick_cnt_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_word_done;
    logic                   w_frame_err;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    // Synchroniser chain on the asynchronous line; resets to idle-high so no
    // false start bit is seen right after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Receiver state and counters register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
        end
    end

    // Next-state and counter logic; everything only moves on an oversample tick.
    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_word_done     = 1'b0;
        w_frame_err     = 1'b0;

        if (rx_tick_i) begin
            // Free-running 4-bit tick count, wraps 15 -> 0.
            w_tick_cnt_next = r_tick_cnt + 4'd1;
            unique case (r_state)
                ST_IDLE: begin
                    w_tick_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next = ST_START;
                    end
                end
                ST_START: begin
                    if (r_tick_cnt == 4'd7) begin
                        w_tick_cnt_next = '0;
                        if (w_rx_s) begin
                            // Line went back high before mid-bit: treat as a glitch.
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next   = ST_DATA;
                            w_bit_cnt_next = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_tick_cnt == 4'd15) begin
                        w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_next = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_tick_cnt == 4'd15) begin
                        if (w_rx_s) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            w_state_next = ST_IDLE;
                            w_word_done  = 1'b1;
                        end else begin
                            w_state_next = ST_BREAK;
                            w_frame_err  = 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    w_tick_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next    = ST_IDLE;
                    w_tick_cnt_next = '0;
                end
            endcase
        end
    end

    // Output register: hand off completed words, report overrun and framing pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_word_done) begin
                if (!r_valid || ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    // Consumer still holds the previous word: keep it, drop the new one.
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled: drives serial frames at 64 clocks per bit
// with a tick every 4 clocks, and checks received words and flags against a
// frame-level reference model.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_tick_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Observed activity, gathered by the monitor.
    logic [7:0] got_q[$];
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    int         valid_cycles = 0;

    // Reference model outputs.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;

    uart_rx_oversampled #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_tick_i  (rx_tick_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clock high out of every four.
    initial begin
        rx_tick_i = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 rx_tick_i = 1'b1;
            @(posedge clk);
            #1 rx_tick_i = 1'b0;
        end
    end

    // Monitor: records accepted words and flag pulses, one line per word.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o) valid_cycles++;
            if (valid_o && ready_i) begin
                got_q.push_back(data_o);
                $display("[%0t] rx word 0x%02h accepted", $time, data_o);
            end
            if (frame_err_o) begin
                ferr_cnt++;
                $display("[%0t] frame error pulse", $time);
            end
            if (overrun_o) begin
                ovr_cnt++;
                $display("[%0t] overrun pulse", $time);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d words", got_q.size());
        $fatal(1, "watchdog expired");
    end

    // Reference model: a frame with a high stop bit delivers its word to an
    // always-ready consumer; a low stop bit yields one framing error, no word.
    function automatic void model_frame(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) exp_q.push_back(d);
        else exp_ferr++;
    endfunction

    // Hold the line at level b for nbits bit periods (leaves time at posedge+1).
    task automatic drive_bits(input logic b, input int nbits);
        rx_i = b;
        if (nbits > 0) begin
            repeat (nbits * BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
        drive_bits(stop_bit, 1);
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (data_o !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %02h want 00", data_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_single_frame();
        int f0, o0, v0;
        ready_i = 1'b1;
        got_q.delete(); exp_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        drive_bits(1'b1, 2);
        n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL single_data: got %02h want %02h", got_q[0], exp_q[0]); end
        end
        n_checks++; if (valid_cycles - v0 !== 1) begin n_errors++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cycles - v0); end
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_errors++; $display("FAIL single_ovr: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch();
        int f0;
        got_q.delete();
        f0 = ferr_cnt;
        rx_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rx_i = 1'b1;
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_start: got %b want 1", busy_o); end
        drive_bits(1'b1, 2);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_end: got %b want 0", busy_o); end
        n_checks++; if (got_q.size() !== 0) begin n_errors++; $display("FAIL glitch_words: got %0d want 0", got_q.size()); end
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_error();
        int f0;
        got_q.delete(); exp_q.delete();
        exp_ferr = 0;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        drive_bits(1'b0, 2);            // line held low well past the stop bit
        drive_bits(1'b1, 1);
        n_checks++; if (ferr_cnt - f0 !== exp_ferr) begin n_errors++; $display("FAIL ferr_count: got %0d want %0d", ferr_cnt - f0, exp_ferr); end
        n_checks++; if (got_q.size() !== 0) begin n_errors++; $display("FAIL ferr_no_word: got %0d want 0", got_q.size()); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ferr_busy: got %b want 0", busy_o); end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        drive_bits(1'b1, 2);
        n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL ferr_next_data: got %02h want %02h", got_q[0], exp_q[0]); end
        end
        n_checks++; if (ferr_cnt - f0 !== exp_ferr) begin n_errors++; $display("FAIL ferr_after: got %0d want %0d", ferr_cnt - f0, exp_ferr); end
    endtask

    task automatic test_overrun();
        int o0;
        got_q.delete();
        o0 = ovr_cnt;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        drive_bits(1'b1, 1);
        send_frame(8'h22, 1'b1);
        drive_bits(1'b1, 2);
        // Consumer stalled: first word held, the second is an overrun.
        n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL ovr_valid_held: got %b want 1", valid_o); end
        n_checks++; if (data_o !== 8'h11) begin n_errors++; $display("FAIL ovr_data_held: got %02h want 11", data_o); end
        n_checks++; if (ovr_cnt - o0 !== 1) begin n_errors++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL ovr_valid_clear: got %b want 0", valid_o); end
        n_checks++; if (data_o !== 8'h11) begin n_errors++; $display("FAIL ovr_data_keep: got %02h want 11", data_o); end
        n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL ovr_accepted: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== 8'h11) begin n_errors++; $display("FAIL ovr_accepted_data: got %02h want 11", got_q[0]); end
        end
        drive_bits(1'b1, 1);
    endtask

    task automatic test_back_to_back();
        int f0, o0;
        got_q.delete(); exp_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        model_frame(8'hAA, 1'b1);
        drive_bits(1'b1, 2);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_errors++; $display("FAIL b2b_flags: got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    endtask

    task automatic test_reset_mid_frame();
        int f0, o0;
        got_q.delete(); exp_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        drive_bits(1'b0, 1);            // start bit of 0xFF
        drive_bits(1'b1, 2);            // first two data bits
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy_o); end
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy_reset: got %b want 0", busy_o); end
        rst_i = 1'b0;
        drive_bits(1'b1, 7);            // rest of 0xFF and its stop bit
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1);
        drive_bits(1'b1, 2);
        n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL rstmid_data: got %02h want %02h", got_q[0], exp_q[0]); end
        end
        n_checks++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_errors++; $display("FAIL rstmid_flags: got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    endtask

    task automatic test_random();
        int         f0, o0, gap;
        logic [7:0] d;
        logic       stop_bit;
        got_q.delete(); exp_q.delete();
        exp_ferr = 0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 5) != 0);
            send_frame(d, stop_bit);
            model_frame(d, stop_bit);
            // A broken frame needs the line to return high before the next start.
            gap = stop_bit ? $urandom_range(0, 2) : $urandom_range(1, 2);
            drive_bits(1'b1, gap);
            if ($urandom_range(0, 1) != 0) begin
                rx_i = 1'b1;
                repeat ($urandom_range(1, 7)) @(posedge clk);
                #1;
            end
        end
        drive_bits(1'b1, 2);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_data[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (ferr_cnt - f0 !== exp_ferr) begin n_errors++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, exp_ferr); end
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_errors++; $display("FAIL rand_ovr: got %0d want 0", ovr_cnt - o0); end
    endtask

    initial begin
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
